fwd_hazard_ctrl: RTL and testbench

//  Forwarding and hazard controller for the 5-stage pipeline. Tracks destination

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/fwd_hazard_ctrl_if.sv | 52 +++++
 rtl/fwd_match.sv | 17 +
 rtl/fwd_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types for the forwarding/hazard controller:
// operand-mux select codes and the per-stage destination record.
package pipe_ctrl_pkg;

  localparam int PIPE_REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [PIPE_REG_AW-1:0] rd;
    logic                   load;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  // Youngest producer wins: an EX hit shadows an older MEM hit on the same register.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the ID stage / EX operand muxes and the forwarding controller.
// Counter signals exist only when FWD_PERF_CNT_EN is defined.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5
`ifdef FWD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic              id_we_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_load_i;
  logic              flush_i;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic              stall_o;
  logic              bubble_o;
`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  fwd_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_we_i, id_rd_i, id_load_i, flush_i,
    input  fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o, stall_cnt_o, fwd_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_we_i, id_rd_i, id_load_i, flush_i,
    output fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o, stall_cnt_o, fwd_cnt_o
  );
`else
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_we_i, id_rd_i, id_load_i, flush_i,
    input  fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_we_i, id_rd_i, id_load_i, flush_i,
    output fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o
  );
`endif

endinterface

// File: rtl/fwd_match.sv
// Compares one ID source index against one in-flight stage entry.
// r0 is hardwired zero, so it never matches a producer.
module fwd_match
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  stage_info_t       stage,
  output logic              hit
);

  assign hit = use_src & stage.valid & stage.we &
               (stage.rd == src) & (src != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW
`ifdef FWD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_ctrl_if.slave   bus
);

  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t id_info;

  logic       hit_a_ex;
  logic       hit_a_mem;
  logic       hit_b_ex;
  logic       hit_b_mem;
  logic       hazard;
  logic       stall;
  logic       bubble;
  logic       issue;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;
  logic [1:0] sel_a_q;
  logic [1:0] sel_b_q;

  fwd_match #(.REG_AW(REG_AW)) u_match_a_ex (
    .src(bus.id_rs_i), .use_src(bus.id_use_rs_i), .stage(ex_q),  .hit(hit_a_ex)
  );
  fwd_match #(.REG_AW(REG_AW)) u_match_a_mem (
    .src(bus.id_rs_i), .use_src(bus.id_use_rs_i), .stage(mem_q), .hit(hit_a_mem)
  );
  fwd_match #(.REG_AW(REG_AW)) u_match_b_ex (
    .src(bus.id_rt_i), .use_src(bus.id_use_rt_i), .stage(ex_q),  .hit(hit_b_ex)
  );
  fwd_match #(.REG_AW(REG_AW)) u_match_b_mem (
    .src(bus.id_rt_i), .use_src(bus.id_use_rt_i), .stage(mem_q), .hit(hit_b_mem)
  );

  // A load in EX cannot forward yet; hold the consumer one cycle unless it is being flushed.
  assign hazard = bus.id_valid_i & ex_q.load & (hit_a_ex | hit_b_ex);
  assign stall  = hazard & ~bus.flush_i;
  assign bubble = stall | bus.flush_i;
  assign issue  = bus.id_valid_i & ~bubble;

  assign sel_a_d = issue ? fwd_sel(hit_a_ex, hit_a_mem) : FWD_RF;
  assign sel_b_d = issue ? fwd_sel(hit_b_ex, hit_b_mem) : FWD_RF;

  always_comb begin
    id_info       = STAGE_BUBBLE;
    id_info.valid = issue;
    id_info.we    = issue & bus.id_we_i;
    id_info.rd    = issue ? bus.id_rd_i : '0;
    id_info.load  = issue & bus.id_load_i;
  end

  // ID -> EX -> MEM stage boundary
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      mem_q   <= ex_q;
      ex_q    <= id_info;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.fwd_a_sel_o = sel_a_q;
  assign bus.fwd_b_sel_o = sel_b_q;
  assign bus.stall_o     = stall;
  assign bus.bubble_o    = bubble;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if ((sel_a_d != FWD_RF) || (sel_b_d != FWD_RF))
        fwd_cnt_q <= sat_inc(fwd_cnt_q);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl against an instruction-history model.
// Counter checks are included when FWD_PERF_CNT_EN is defined.
module tb_fwd_hazard_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    bit valid;
    bit we;
    bit load;
    int rd;
  } ins_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  ins_t   hist [2];          // [0] = instruction now in EX, [1] = now in MEM
  int     exp_a;
  int     exp_b;
  longint exp_stall_cnt;
  longint exp_fwd_cnt;
  bit     last_stall;
  bit     last_bubble;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Which pipeline slot supplies the newest value of src: 0 = regfile, 1 = EX, 2 = MEM.
  function automatic int producer(input int src, input bit use_src);
    if (!use_src || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].valid && hist[k].we && hist[k].rd == src) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) hist[k] = '{valid: 0, we: 0, load: 0, rd: 0};
    exp_a = 0;
    exp_b = 0;
    exp_stall_cnt = 0;
    exp_fwd_cnt = 0;
  endtask

  task automatic cycle(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit we, input int rd, input bit ld, input bit fl);
    bit hz, st, bb, issue;
    int na, nb;
    bus.id_valid_i  = v;
    bus.id_rs_i     = rs[4:0];
    bus.id_rt_i     = rt[4:0];
    bus.id_use_rs_i = urs;
    bus.id_use_rt_i = urt;
    bus.id_we_i     = we;
    bus.id_rd_i     = rd[4:0];
    bus.id_load_i   = ld;
    bus.flush_i     = fl;
    @(negedge clk_i);
    hz = v && hist[0].valid && hist[0].load && hist[0].we && hist[0].rd != 0 &&
         ((urs && rs == hist[0].rd) || (urt && rt == hist[0].rd));
    st = hz && !fl;
    bb = st || fl;
    check("stall",  bus.stall_o,     st);
    check("bubble", bus.bubble_o,    bb);
    check("sel_a",  bus.fwd_a_sel_o, exp_a);
    check("sel_b",  bus.fwd_b_sel_o, exp_b);
`ifdef FWD_PERF_CNT_EN
    check("stall_cnt", bus.stall_cnt_o, exp_stall_cnt);
    check("fwd_cnt",   bus.fwd_cnt_o,   exp_fwd_cnt);
`endif
    last_stall  = bus.stall_o;
    last_bubble = bus.bubble_o;
    issue = v && !bb;
    na = issue ? producer(rs, urs) : 0;
    nb = issue ? producer(rt, urt) : 0;
    @(posedge clk_i);
    #1;
    hist[1] = hist[0];
    hist[0] = '{valid: issue, we: issue && we, load: issue && ld, rd: issue ? rd : 0};
    exp_a = na;
    exp_b = nb;
    if (st) exp_stall_cnt++;
    if (na != 0 || nb != 0) exp_fwd_cnt++;
  endtask

  task automatic alu(input int rd, input int rs, input int rt);
    cycle(1, rs, rt, 1, 1, 1, rd, 0, 0);
  endtask

  task automatic lw(input int rd, input int rs);
    cycle(1, rs, 0, 1, 0, 1, rd, 1, 0);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    bus.id_valid_i = 0; bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_use_rs_i = 0;
    bus.id_use_rt_i = 0; bus.id_we_i = 0; bus.id_rd_i = '0; bus.id_load_i = 0; bus.flush_i = 0;
    #12;
    check("rst_sel_a", bus.fwd_a_sel_o, 0);
    check("rst_sel_b", bus.fwd_b_sel_o, 0);
    check("rst_stall", bus.stall_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // load-use: one stall cycle, bubble in EX, then MEM/WB forwarding
    lw(2, 1);
    alu(6, 2, 7);
    check("t3_stall_first", last_stall, 1);
    check("t3_bubble_sel_a", bus.fwd_a_sel_o, 0);
    alu(6, 2, 7);
    check("t3_stall_second", last_stall, 0);
    check("t3_sel_a", bus.fwd_a_sel_o, 2);
    check("t3_sel_b", bus.fwd_b_sel_o, 0);
`ifdef FWD_PERF_CNT_EN
    check("t6_stall_cnt", bus.stall_cnt_o, 1);
`endif

    // back-to-back ALU dependency
    alu(3, 1, 1);
    alu(4, 3, 3);
    check("t1_stall", last_stall, 0);
    check("t1_sel_a", bus.fwd_a_sel_o, 1);
    check("t1_sel_b", bus.fwd_b_sel_o, 1);

    // one-instruction gap
    alu(3, 1, 1);
    nop();
    alu(5, 3, 1);
    check("t2_sel_a", bus.fwd_a_sel_o, 2);
    check("t2_sel_b", bus.fwd_b_sel_o, 0);

    // youngest producer wins, r0 never forwarded
    alu(3, 1, 1);
    alu(3, 2, 2);
    alu(8, 3, 3);
    check("t4_sel_a", bus.fwd_a_sel_o, 1);
    check("t4_sel_b", bus.fwd_b_sel_o, 1);
    alu(0, 1, 1);
    alu(9, 0, 0);
    check("t4_r0_sel_a", bus.fwd_a_sel_o, 0);
    check("t4_r0_sel_b", bus.fwd_b_sel_o, 0);

    // flush coinciding with a load-use hazard
    lw(2, 1);
    cycle(1, 2, 7, 1, 1, 1, 6, 0, 1);
    check("t5_stall", last_stall, 0);
    check("t5_bubble", last_bubble, 1);
    check("t5_sel_a", bus.fwd_a_sel_o, 0);
    check("t5_sel_b", bus.fwd_b_sel_o, 0);

    // asynchronous reset mid-stream while a stall and forwarding are active
    alu(3, 1, 1);
    lw(2, 3);
    bus.id_valid_i = 1; bus.id_rs_i = 5'd2; bus.id_rt_i = 5'd7; bus.id_use_rs_i = 1;
    bus.id_use_rt_i = 1; bus.id_we_i = 1; bus.id_rd_i = 5'd6; bus.id_load_i = 0; bus.flush_i = 0;
    #1;
    check("t6_pre_stall", bus.stall_o, 1);
    check("t6_pre_sel_a", bus.fwd_a_sel_o, 1);
    rst_i = 1'b0;
    #1;
    check("t6_sel_a", bus.fwd_a_sel_o, 0);
    check("t6_sel_b", bus.fwd_b_sel_o, 0);
    check("t6_stall", bus.stall_o, 0);
`ifdef FWD_PERF_CNT_EN
    check("t6_stall_cnt_rst", bus.stall_cnt_o, 0);
    check("t6_fwd_cnt_rst", bus.fwd_cnt_o, 0);
`endif
    model_reset();
    rst_i = 1'b1;

    // randomized traffic over a small register set to provoke frequent matches
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 99) < 80),
            $urandom_range(0, 3), ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 10));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
